// File: rtl/leaf_collect_pkg.sv
// Shared types, defaults and pointer helper for the leaf collector family.
package leaf_collect_pkg;

  localparam int unsigned DEFAULT_NUM_SRC = 10;
  localparam int unsigned DEFAULT_DATA_W  = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Round-robin successor of idx among n slots, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx == n - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_SRC = 10,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  // Scan req starting at ptr; the first hit wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = IDX_W'((32'(ptr) + off) % NUM_SRC);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leaf_rr_collector.sv
// Round-robin collector: arbitrates child streams into one registered, source-tagged stream.
module leaf_rr_collector
  import leaf_collect_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEFAULT_NUM_SRC,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_SRC)-1:0]  out_src_id,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            fwd_count,
  output logic                        busy
);

  localparam int unsigned SRC_ID_W = $clog2(NUM_SRC);

  out_state_e          state_q, state_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SRC_ID_W-1:0] out_src_id_q, out_src_id_d;
  logic [SRC_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    fwd_count_q, fwd_count_d;

  logic [DATA_W-1:0]   src_word [NUM_SRC];
  logic [NUM_SRC-1:0]  gnt_onehot;
  logic [SRC_ID_W-1:0] gnt_idx;
  logic                gnt_any;
  logic                load_en;
  logic                grant;
  logic                drain;

  // Unpack the flat child payload bus.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = src_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (SRC_ID_W)
  ) u_rr_pick (
    .req        (src_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Next-state, load/drain decisions and child accept strobes.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_src_id_d = out_src_id_q;
    rr_ptr_d     = rr_ptr_q;
    fwd_count_d  = fwd_count_q;

    drain   = (state_q == OUT_FULL) && out_ready;
    load_en = enable && ((state_q == OUT_EMPTY) || drain);
    grant   = load_en && gnt_any;

    if (drain) begin
      fwd_count_d = fwd_count_q + CNT_W'(1);
    end

    if (grant) begin
      state_d      = OUT_FULL;
      out_data_d   = src_word[gnt_idx];
      out_src_id_d = gnt_idx;
      rr_ptr_d     = SRC_ID_W'(rr_next(32'(gnt_idx), NUM_SRC));
    end else if (drain) begin
      state_d = OUT_EMPTY;
    end

    src_ready = (grant && !rst) ? gnt_onehot : '0;
  end

  // Output register, pointer, counter and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= OUT_EMPTY;
      out_data_q   <= '0;
      out_src_id_q <= '0;
      rr_ptr_q     <= '0;
      fwd_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_src_id_q <= out_src_id_d;
      rr_ptr_q     <= rr_ptr_d;
      fwd_count_q  <= fwd_count_d;
    end
  end

  assign out_valid  = (state_q == OUT_FULL);
  assign out_data   = out_data_q;
  assign out_src_id = out_src_id_q;
  assign fwd_count  = fwd_count_q;
  assign busy       = out_valid || (|src_valid);

endmodule

// File: tb/tb_leaf_rr_collector.sv
// Self-checking bench for leaf_rr_collector: directed scenarios plus randomized traffic vs. a queue-free model.
module tb_leaf_rr_collector;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int CW = 16;

  logic            clk;
  logic            rst;
  logic            enable;
  logic [N-1:0]    src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_src_id;
  logic            out_ready;
  logic [CW-1:0]   fwd_count;
  logic            busy;

  int checks = 0;
  int errors = 0;

  leaf_rr_collector dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src_id (out_src_id),
    .out_ready  (out_ready),
    .fwd_count  (fwd_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; src_valid = '0; src_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Spec rule: first valid child at or after ptr, wrapping; -1 when none.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; src_valid = '1; src_data = '1; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_src_id, out_data, fwd_count} !== {1'b0, 4'd0, 16'd0, 16'd0}) begin
      errors++; $display("FAIL reset_outputs got v=%b id=%0d d=%h cnt=%0d want all zero", out_valid, out_src_id, out_data, fwd_count);
    end
    checks++;
    if (src_ready !== '0) begin
      errors++; $display("FAIL reset_src_ready got %b want 0", src_ready);
    end
    rst = 1'b0; src_valid = '0; src_data = '0; out_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] exp;
    do_reset();
    src_valid = 10'b0000001000; src_data[3*DW +: DW] = 16'hA5A5; out_ready = 1'b1;
    #1;
    checks++;
    if (src_ready !== 10'b0000001000) begin
      errors++; $display("FAIL single_ready got %b want 0000001000", src_ready);
    end
    tick();
    src_valid = '0;
    #1;
    checks++;
    if ({out_valid, out_src_id, out_data, fwd_count, src_ready} !== {1'b1, 4'd3, 16'hA5A5, 16'd0, 10'd0}) begin
      errors++; $display("FAIL single_out got v=%b id=%0d d=%h cnt=%0d rdy=%b want 1/3/a5a5/0/0", out_valid, out_src_id, out_data, fwd_count, src_ready);
    end
    tick();
    checks++;
    if ({out_valid, fwd_count} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL single_accept got v=%b cnt=%0d want 0/1", out_valid, fwd_count);
    end
    src_valid = '1;
    exp = 10'b0000010000;
    #1;
    checks++;
    if (src_ready !== exp) begin
      errors++; $display("FAIL single_ptr4 got %b want %b", src_ready, exp);
    end
    src_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 16'(16'h1000 + i);
    src_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if ({out_valid, out_src_id, out_data} !== {1'b1, 4'(k % N), 16'(16'h1000 + k % N)}) begin
        errors++; $display("FAIL b2b_seq[%0d] got v=%b id=%0d d=%h want 1/%0d/%h", k, out_valid, out_src_id, out_data, k % N, 16'h1000 + k % N);
      end
    end
    src_valid = '0;
    tick();
    checks++;
    if ({out_valid, fwd_count} !== {1'b0, 16'd12}) begin
      errors++; $display("FAIL b2b_count got v=%b cnt=%0d want 0/12", out_valid, fwd_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_valid = 10'b0000000100; src_data[2*DW +: DW] = 16'hBEEF; out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_valid, out_src_id, out_data, fwd_count, src_ready} !== {1'b1, 4'd2, 16'hBEEF, 16'd0, 10'd0}) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h cnt=%0d rdy=%b want 1/2/beef/0/0", k, out_valid, out_src_id, out_data, fwd_count, src_ready);
      end
      tick();
    end
    src_valid = '0; out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, fwd_count} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL bp_release got v=%b cnt=%0d want 0/1", out_valid, fwd_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    src_valid = 10'b0100000000; src_data[8*DW +: DW] = 16'h0808;
    src_data[9*DW +: DW] = 16'h0909; src_data[0 +: DW] = 16'h0000;
    tick();
    src_valid = 10'b1000000001;
    #1;
    checks++;
    if (src_ready !== 10'b1000000000) begin
      errors++; $display("FAIL wrap_ptr9 got %b want 1000000000", src_ready);
    end
    tick();
    checks++;
    if ({out_src_id, out_data, src_ready} !== {4'd9, 16'h0909, 10'b0000000001}) begin
      errors++; $display("FAIL wrap_to0 got id=%0d d=%h rdy=%b want 9/0909/0000000001", out_src_id, out_data, src_ready);
    end
    tick();
    checks++;
    if ({out_src_id, src_ready} !== {4'd0, 10'b1000000000}) begin
      errors++; $display("FAIL wrap_ptr1 got id=%0d rdy=%b want 0/1000000000", out_src_id, src_ready);
    end
    src_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    src_valid = '1; out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({out_valid, fwd_count} !== {1'b1, 16'd2}) begin
      errors++; $display("FAIL arst_pre got v=%b cnt=%0d want 1/2", out_valid, fwd_count);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, fwd_count, src_ready} !== {1'b0, 16'd0, 10'd0}) begin
      errors++; $display("FAIL arst_async got v=%b cnt=%0d rdy=%b want 0/0/0", out_valid, fwd_count, src_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (src_ready !== 10'b0000000001) begin
      errors++; $display("FAIL arst_first_grant got %b want 0000000001", src_ready);
    end
    src_valid = '0;
    tick();
  endtask

  task automatic test_enable_drain();
    do_reset();
    src_valid = 10'b0000100000; src_data[5*DW +: DW] = 16'h5555; out_ready = 1'b0;
    tick();
    src_data[5*DW +: DW] = 16'h6666;
    enable = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, src_ready} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL en_hold got v=%b rdy=%b want 1/0", out_valid, src_ready);
    end
    tick();
    checks++;
    if ({out_valid, fwd_count, src_ready} !== {1'b0, 16'd1, 10'd0}) begin
      errors++; $display("FAIL en_drain got v=%b cnt=%0d rdy=%b want 0/1/0", out_valid, fwd_count, src_ready);
    end
    tick();
    checks++;
    if ({out_valid, busy} !== {1'b0, 1'b1}) begin
      errors++; $display("FAIL en_idle got v=%b busy=%b want 0/1", out_valid, busy);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (src_ready !== 10'b0000100000) begin
      errors++; $display("FAIL en_resume got %b want 0000100000", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if ({out_valid, out_src_id, out_data} !== {1'b1, 4'd5, 16'h6666}) begin
      errors++; $display("FAIL en_newword got v=%b id=%0d d=%h want 1/5/6666", out_valid, out_src_id, out_data);
    end
    tick();
  endtask

  task automatic test_random();
    logic          m_v;
    logic [DW-1:0] m_d;
    int            m_id, m_ptr, g;
    logic [CW-1:0] m_cnt;
    logic [N-1:0]  exp_rdy;
    logic          load;
    do_reset();
    m_v = 1'b0; m_d = '0; m_id = 0; m_ptr = 0; m_cnt = '0;
    for (int c = 0; c < 500; c++) begin
      src_valid = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      #1;
      g = pick(src_valid, m_ptr);
      load = enable && (!m_v || out_ready);
      exp_rdy = '0;
      if (load && g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if ({src_ready, busy} !== {exp_rdy, m_v | (|src_valid)}) begin
        errors++; $display("FAIL rnd_ready[%0d] got rdy=%b busy=%b want %b/%b", c, src_ready, busy, exp_rdy, m_v | (|src_valid));
      end
      checks++;
      if ({out_valid, out_src_id, out_data, fwd_count} !== {m_v, 4'(m_id), m_d, m_cnt}) begin
        errors++; $display("FAIL rnd_out[%0d] got v=%b id=%0d d=%h cnt=%0d want %b/%0d/%h/%0d", c, out_valid, out_src_id, out_data, fwd_count, m_v, m_id, m_d, m_cnt);
      end
      if (m_v && out_ready) m_cnt = m_cnt + 1'b1;
      if (load && g >= 0) begin
        m_v = 1'b1; m_id = g; m_d = src_data[g*DW +: DW]; m_ptr = (g + 1) % N;
      end else if (m_v && out_ready) begin
        m_v = 1'b0;
      end
      tick();
    end
    enable = 1'b1; src_valid = '0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_count_wrap();
    do_reset();
    src_valid = 10'b0000000001; out_ready = 1'b1; enable = 1'b1;
    repeat (65536) tick();
    checks++;
    if ({out_valid, fwd_count} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL cnt_max got v=%b cnt=%h want 1/ffff", out_valid, fwd_count);
    end
    tick();
    checks++;
    if (fwd_count !== 16'h0000) begin
      errors++; $display("FAIL cnt_wrap got %h want 0000", fwd_count);
    end
    src_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_enable_drain();
    test_random();
    test_count_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
